// File: rtl/chirp_burst_tx.sv
// chirp_burst_tx: strobe-paced square-wave ultrasonic burst followed by a silent guard interval.
// Build macro CHIRP_TAPER_EN halves the first and last burst samples.
module chirp_burst_tx #(
  parameter int                 BURST_LEN = 8,
  parameter logic signed [15:0] AMPLITUDE = 16'sd20000,
  parameter int                 GUARD_LEN = 64
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               step_in,
  input  logic               start_in,
  input  logic               abort_in,
  output logic signed [15:0] amp_out,
  output logic               busy_out,
  output logic               sync_out,
  output logic               done_out
);

  // state | meaning
  // IDLE  | silent, waiting for start_in
  // ARMED | start accepted, first sample goes out on the next step_in
  // BURST | emitting samples k = 0 .. BURST_LEN-1, one per step_in
  // GUARD | silent, counting GUARD_LEN step_in periods before done_out
  typedef enum logic [1:0] {IDLE, ARMED, BURST, GUARD} state_t;

  localparam logic [7:0]  K_LAST = 8'(BURST_LEN - 1);
  localparam logic [15:0] G_LAST = 16'(GUARD_LEN - 1);

  state_t      state;
  logic [7:0]  sample_cnt;
  logic [15:0] guard_cnt;

  function automatic logic signed [15:0] sample_val(input logic [7:0] k);
    logic signed [15:0] v;
    v = k[0] ? -AMPLITUDE : AMPLITUDE;
`ifdef CHIRP_TAPER_EN
    if (k == 8'd0 || k == K_LAST) v = v >>> 1;
`else
    v = v;
`endif
    return v;
  endfunction

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state      <= IDLE;
      amp_out    <= '0;
      busy_out   <= 1'b0;
      sync_out   <= 1'b0;
      done_out   <= 1'b0;
      sample_cnt <= '0;
      guard_cnt  <= '0;
    end else begin
      sync_out <= 1'b0;
      done_out <= 1'b0;
      // abort outranks both start and step in every state
      if (abort_in) begin
        state      <= IDLE;
        amp_out    <= '0;
        busy_out   <= 1'b0;
        sample_cnt <= '0;
        guard_cnt  <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (start_in) begin
              state    <= ARMED;
              busy_out <= 1'b1;
            end
          end
          ARMED: begin
            if (step_in) begin
              state      <= BURST;
              amp_out    <= sample_val(8'd0);
              sync_out   <= 1'b1;
              sample_cnt <= '0;
            end
          end
          BURST: begin
            if (step_in) begin
              if (sample_cnt == K_LAST) begin
                state     <= GUARD;
                amp_out   <= '0;
                guard_cnt <= '0;
              end else begin
                sample_cnt <= sample_cnt + 8'd1;
                amp_out    <= sample_val(sample_cnt + 8'd1);
              end
            end
          end
          GUARD: begin
            if (step_in) begin
              if (guard_cnt == G_LAST) begin
                state      <= IDLE;
                busy_out   <= 1'b0;
                done_out   <= 1'b1;
                guard_cnt  <= '0;
                sample_cnt <= '0;
              end else begin
                guard_cnt <= guard_cnt + 16'd1;
              end
            end
          end
          default: begin
            state    <= IDLE;
            amp_out  <= '0;
            busy_out <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_chirp_burst_tx.sv
// Bench for chirp_burst_tx: directed scenarios with randomized strobe spacing and abort points.
// Expected samples come from a strobe-index model of the burst/guard schedule.
module tb_chirp_burst_tx;

  localparam int BL   = 8;
  localparam int GL   = 4;
  localparam int AMP  = 20000;
  localparam int LAST = BL + GL;  // strobe index (from sample 0) that completes the guard

  logic clk_in = 1'b0;
  logic rst_in = 1'b0;
  logic step_in = 1'b0;
  logic start_in = 1'b0;
  logic abort_in = 1'b0;
  logic signed [15:0] amp_out;
  logic busy_out, sync_out, done_out;

  int checks = 0;
  int failures = 0;
  int sync_cnt = 0;
  int done_cnt = 0;

  always #5 clk_in = ~clk_in;

  chirp_burst_tx #(
    .BURST_LEN(BL),
    .AMPLITUDE(16'sd20000),
    .GUARD_LEN(GL)
  ) dut (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .step_in (step_in),
    .start_in(start_in),
    .abort_in(abort_in),
    .amp_out (amp_out),
    .busy_out(busy_out),
    .sync_out(sync_out),
    .done_out(done_out)
  );

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // expected amp_out after the i-th strobe counted from the first burst sample
  function automatic int exp_amp(input int i);
    int v;
    if (i >= BL) return 0;
    v = (i % 2 == 0) ? AMP : -AMP;
`ifdef CHIRP_TAPER_EN
    if (i == 0 || i == BL - 1) v = v / 2;
`endif
    return v;
  endfunction

  always @(negedge clk_in) begin
    if (sync_out) sync_cnt++;
    if (done_out) done_cnt++;
    if (sync_out || done_out) chk("sync_done_excl", sync_out & done_out, 0);
  end

  task automatic cycle(input logic st, input logic sp, input logic ab);
    @(negedge clk_in);
    start_in = st;
    step_in  = sp;
    abort_in = ab;
    @(posedge clk_in);
    #1;
    start_in = 1'b0;
    step_in  = 1'b0;
    abort_in = 1'b0;
  endtask

  task automatic gap(input int n, input bit inj, input int amp_e, input bit busy_e);
    for (int c = 0; c < n; c++) begin
      cycle(inj && ($urandom_range(0, 1) == 1), 1'b0, 1'b0);
      chk("hold_amp", amp_out, amp_e);
      chk("hold_sync", sync_out, 0);
      chk("hold_done", done_out, 0);
      chk("hold_busy", busy_out, busy_e);
    end
  endtask

  task automatic strobes(input int first, input int last, input int maxgap, input bit inj);
    for (int i = first; i <= last; i++) begin
      gap($urandom_range(1, maxgap), inj, (i == 0) ? 0 : exp_amp(i - 1), 1'b1);
      cycle(inj && ($urandom_range(0, 1) == 1), 1'b1, 1'b0);
      chk("amp", amp_out, exp_amp(i));
      chk("sync", sync_out, i == 0);
      chk("done", done_out, i == LAST);
      chk("busy", busy_out, i != LAST);
    end
  endtask

  task automatic arm();
    cycle(1'b1, 1'b0, 1'b0);
    chk("arm_busy", busy_out, 1);
    chk("arm_amp", amp_out, 0);
    chk("arm_sync", sync_out, 0);
  endtask

  task automatic silent_steps(input string tag, input int n);
    for (int c = 0; c < n; c++) begin
      cycle(1'b0, 1'b1, 1'b0);
      chk({tag, "_amp"}, amp_out, 0);
      chk({tag, "_busy"}, busy_out, 0);
      chk({tag, "_done"}, done_out, 0);
      chk({tag, "_sync"}, sync_out, 0);
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_amp"}, amp_out, 0);
    chk({tag, "_busy"}, busy_out, 0);
    chk({tag, "_sync"}, sync_out, 0);
    chk({tag, "_done"}, done_out, 0);
  endtask

  int s0, d0, cut, kind;

  initial begin
    // reset state
    rst_in = 1'b0;
    repeat (3) @(posedge clk_in);
    #1;
    check_all_zero("reset");
    @(negedge clk_in);
    rst_in = 1'b1;

    // nominal burst with wide strobe spacing
    arm();
    strobes(0, LAST, 1024, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    check_all_zero("nominal_after");

    // start and step in the same IDLE cycle: no sample yet
    cycle(1'b1, 1'b1, 1'b0);
    chk("coinc_amp", amp_out, 0);
    chk("coinc_sync", sync_out, 0);
    chk("coinc_busy", busy_out, 1);
    strobes(0, LAST, 20, 1'b0);

    // abort at k=3, step possibly coincident
    arm();
    strobes(0, 3, 20, 1'b0);
    cycle(1'b0, 1'($urandom_range(0, 1)), 1'b1);
    check_all_zero("abort");
    silent_steps("post_abort", GL + 3);
    arm();
    strobes(0, LAST, 20, 1'b0);

    // abort beats start in IDLE and step in ARMED
    cycle(1'b1, 1'b0, 1'b1);
    check_all_zero("abort_vs_start");
    arm();
    cycle(1'b0, 1'b1, 1'b1);
    check_all_zero("abort_vs_step");

    // restart requests while busy are ignored
    s0 = sync_cnt;
    d0 = done_cnt;
    arm();
    strobes(0, LAST, 20, 1'b1);
    cycle(1'b0, 1'b0, 1'b0);
    chk("restart_sync_count", sync_cnt - s0, 1);
    chk("restart_done_count", done_cnt - d0, 1);
    chk("restart_idle_busy", busy_out, 0);

    // one-cycle reset in the middle of the guard
    arm();
    strobes(0, BL + 2, 20, 1'b0);
    @(negedge clk_in);
    rst_in = 1'b0;
    @(posedge clk_in);
    #1;
    rst_in = 1'b1;
    check_all_zero("rst_guard");
    silent_steps("post_rst", GL + 2);
    arm();
    strobes(0, LAST, 20, 1'b0);

    // random bursts cut short by abort or reset
    for (int r = 0; r < 8; r++) begin
      arm();
      kind = $urandom_range(0, 2);
      cut  = $urandom_range(0, LAST - 1);
      if (kind == 0) begin
        strobes(0, LAST, 12, 1'b1);
      end else begin
        strobes(0, cut, 12, 1'b0);
        if (kind == 1) begin
          cycle(1'b1, 1'($urandom_range(0, 1)), 1'b1);
        end else begin
          @(negedge clk_in);
          rst_in = 1'b0;
          @(posedge clk_in);
          #1;
          rst_in = 1'b1;
        end
        check_all_zero("rand_cut");
        silent_steps("rand_post", 2);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
